// File: rtl/rvfi_channel_serializer.sv
// rvfi_channel_serializer
//
// Funnels the multi-channel RVFI retirement stream (NRET channels per cycle)
// into one in-order channel with a valid/ready handshake. Valid channels are
// packed in ascending channel order into a circular FIFO of DEPTH entries.
// A checker downstream then sees every retirement one at a time.
//
// Optional feature macro: RVFI_SERIAL_ORDER_CHECK_EN
//   When defined, the block tracks the expected order index of the next pop.
//   It raises the sticky order_err flag if a popped order is not consecutive.
//   When undefined, order_err is tied to 0.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   rvfi_valid           per-channel retire strobe             [NRET]
//   rvfi_order           per-channel order index               [NRET*8]
//   rvfi_insn            per-channel instruction word          [NRET*32]
//   rvfi_rd              per-channel destination register      [NRET*5]
//   rvfi_pre_pc          per-channel PC before retirement      [NRET*XLEN]
//   rvfi_post_pc         per-channel PC after retirement       [NRET*XLEN]
//   rvfi_post_rd         per-channel rd writeback value        [NRET*XLEN]
//   rvfi_post_trap       per-channel trap flag                 [NRET]
//   out_valid/out_ready  head-of-queue handshake
//   out_*                head packet fields (single-channel widths)
//   count                FIFO occupancy
//   overflow             sticky: a whole retirement burst was dropped
//   order_err            sticky: non-consecutive order popped (feature only)
module rvfi_channel_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [NRET*8-1:0]        rvfi_order,
    input  logic [NRET*32-1:0]       rvfi_insn,
    input  logic [NRET*5-1:0]        rvfi_rd,
    input  logic [NRET*XLEN-1:0]     rvfi_pre_pc,
    input  logic [NRET*XLEN-1:0]     rvfi_post_pc,
    input  logic [NRET*XLEN-1:0]     rvfi_post_rd,
    input  logic [NRET-1:0]          rvfi_post_trap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_order,
    output logic [31:0]              out_insn,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_pre_pc,
    output logic [XLEN-1:0]          out_post_pc,
    output logic [XLEN-1:0]          out_post_rd,
    output logic                     out_post_trap,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     order_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = 8 + 32 + 5 + 3 * XLEN + 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [PW-1:0] pkt  [NRET];
    logic [AW-1:0] slot [NRET];
    logic [CW-1:0] push_n;
    logic          pop;
    logic          push_ok;
    logic [PW-1:0] head;

    // Pack each channel and give it the slot that follows the valid
    // channels below it. This squeezes out gaps in rvfi_valid.
    always_comb begin
        push_n = '0;
        for (int ch = 0; ch < NRET; ch++) begin
            pkt[ch]  = {rvfi_order[ch*8 +: 8], rvfi_insn[ch*32 +: 32],
                        rvfi_rd[ch*5 +: 5], rvfi_pre_pc[ch*XLEN +: XLEN],
                        rvfi_post_pc[ch*XLEN +: XLEN],
                        rvfi_post_rd[ch*XLEN +: XLEN], rvfi_post_trap[ch]};
            slot[ch] = AW'((32'(wr_ptr) + 32'(push_n)) % DEPTH);
            push_n   = push_n + CW'(rvfi_valid[ch]);
        end
    end

    // A burst is all-or-nothing. If it does not fit after this cycle's
    // pop, it is dropped completely.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = (32'(count) + 32'(push_n) - 32'(pop)) <= DEPTH;

    // Storage carries no reset. Only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int ch = 0; ch < NRET; ch++) begin
                if (rvfi_valid[ch]) begin
                    mem[slot[ch]] <= pkt[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= AW'((32'(rd_ptr) + 32'd1) % DEPTH);
            end
            if (push_ok) begin
                wr_ptr <= AW'((32'(wr_ptr) + 32'(push_n)) % DEPTH);
                count  <= count + push_n - CW'(pop);
            end else begin
                count    <= count - CW'(pop);
                overflow <= 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];
    assign {out_order, out_insn, out_rd, out_pre_pc, out_post_pc,
            out_post_rd, out_post_trap} = head;

`ifdef RVFI_SERIAL_ORDER_CHECK_EN
    logic [7:0] exp_order;
    logic       exp_valid;

    // The first pop after reset only seeds the expectation. Each later pop
    // is compared against it and then re-seeds it. This way one gap is
    // reported once and does not fail every retirement after it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_order <= 8'd0;
            exp_valid <= 1'b0;
            order_err <= 1'b0;
        end else if (pop) begin
            if (exp_valid && (out_order != exp_order)) begin
                order_err <= 1'b1;
            end
            exp_order <= out_order + 8'd1;
            exp_valid <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule
